program_load_sequencer: RTL

//  Top-level sequencer for the mini-core CPU. After reset it streams a program

---
 rtl/program_load_sequencer_if.sv | 29 ++
 rtl/program_load_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/program_load_sequencer_if.sv
// Load-port and memory-write bundle between the host and the program-load sequencer.
// master = host/testbench side, slave = sequencer side.
interface program_load_sequencer_if #(
  parameter int IADDR_W = 5,
  parameter int DADDR_W = 6,
  parameter int IW      = 20,
  parameter int DW      = 8
);
  logic               ld_valid;
  logic               ld_ready;
  logic [IW-1:0]      ld_data;
  logic               ld_last;
  logic               inst_we;
  logic [IADDR_W-1:0] inst_waddr;
  logic [IW-1:0]      inst_wdata;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_waddr;
  logic [DW-1:0]      dmem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, inst_we, inst_waddr, inst_wdata, dmem_we, dmem_waddr, dmem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, inst_we, inst_waddr, inst_wdata, dmem_we, dmem_waddr, dmem_wdata
  );
endinterface

// File: rtl/program_load_sequencer.sv
// Mini-core sequencer: streams program and data into memory, runs the CPU until halt.
// Optional run-cycle watchdog enabled by defining SEQ_WATCHDOG_EN.
//
// state    | meaning
// S_IDLE   | after reset, waiting for start
// S_LOAD_I | accepting instruction beats
// S_LOAD_D | accepting data beats
// S_RUN    | pipeline released, counting cycles until halt
// S_DONE   | CPU halted, done held until start
// S_ERROR  | load overflow or watchdog, err held until start
module program_load_sequencer #(
  parameter int IADDR_W = 5,
  parameter int DADDR_W = 6,
  parameter int IW      = 20,
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_CYC = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  program_load_sequencer_if.slave  bus,
  input  logic                     i_cpu_halted,
  output logic                     o_cpu_run,
  output logic                     o_done,
  output logic                     o_err,
  output logic [CNT_W-1:0]         o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IADDR_W-1:0] r_inst_ptr;
  logic [DADDR_W-1:0] r_dmem_ptr;
  logic               r_inst_we;
  logic [IADDR_W-1:0] r_inst_waddr;
  logic [IW-1:0]      r_inst_wdata;
  logic               r_dmem_we;
  logic [DADDR_W-1:0] r_dmem_waddr;
  logic [DW-1:0]      r_dmem_wdata;
  logic               r_cpu_run;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               w_ready;
  logic               w_accept;
  logic               w_start_ok;
  logic               w_timeout;

  assign w_ready    = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
  assign w_accept   = bus.ld_valid & w_ready;
  assign w_start_ok = i_start &
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] LP_LIMIT_M1 = CNT_W'(MAX_CYC - 1);
  // Fires on the edge that would bring the count up to MAX_CYC.
  assign w_timeout = (r_cycle_count == LP_LIMIT_M1);
`else
  logic w_unused_max_cyc;
  assign w_unused_max_cyc = (MAX_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) w_state_nxt = S_LOAD_I;
      end
      S_LOAD_I: begin
        if (w_accept) begin
          if (bus.ld_last)          w_state_nxt = S_LOAD_D;
          else if (r_inst_ptr == '1) w_state_nxt = S_ERROR;
        end
      end
      S_LOAD_D: begin
        if (w_accept) begin
          if (bus.ld_last)          w_state_nxt = S_RUN;
          else if (r_dmem_ptr == '1) w_state_nxt = S_ERROR;
        end
      end
      S_RUN: begin
        if (i_cpu_halted)   w_state_nxt = S_DONE;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_inst_ptr    <= '0;
      r_dmem_ptr    <= '0;
      r_inst_we     <= 1'b0;
      r_inst_waddr  <= '0;
      r_inst_wdata  <= '0;
      r_dmem_we     <= 1'b0;
      r_dmem_waddr  <= '0;
      r_dmem_wdata  <= '0;
      r_cpu_run     <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_inst_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_cpu_run <= (w_state_nxt == S_RUN);
      if (w_start_ok) begin
        r_inst_ptr    <= '0;
        r_dmem_ptr    <= '0;
        r_done        <= 1'b0;
        r_err         <= 1'b0;
        r_cycle_count <= '0;
      end
      // Pointers stop at the top address; overflow is handled by the FSM, never by wrapping.
      if ((r_state == S_LOAD_I) && w_accept) begin
        r_inst_we    <= 1'b1;
        r_inst_waddr <= r_inst_ptr;
        r_inst_wdata <= bus.ld_data;
        if (r_inst_ptr != '1) r_inst_ptr <= r_inst_ptr + 1'b1;
      end
      if ((r_state == S_LOAD_D) && w_accept) begin
        r_dmem_we    <= 1'b1;
        r_dmem_waddr <= r_dmem_ptr;
        r_dmem_wdata <= bus.ld_data[DW-1:0];
        if (r_dmem_ptr != '1) r_dmem_ptr <= r_dmem_ptr + 1'b1;
      end
      if ((r_state == S_RUN) && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 1'b1;
      if ((r_state == S_RUN) && (w_state_nxt == S_DONE)) r_done <= 1'b1;
      if ((r_state != S_ERROR) && (w_state_nxt == S_ERROR)) r_err <= 1'b1;
    end
  end

  assign bus.ld_ready   = w_ready;
  assign bus.inst_we    = r_inst_we;
  assign bus.inst_waddr = r_inst_waddr;
  assign bus.inst_wdata = r_inst_wdata;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_waddr = r_dmem_waddr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign o_cpu_run      = r_cpu_run;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_cycle_count  = r_cycle_count;

endmodule
